// File: rtl/ifetch_pkg.sv
// Shared fetch-stage types: phase vector layout and fetch FSM encodings.
// Imported by the fetch stage and its prefetch queue.
`ifndef PHASE_H
`define PHASE_H 3
`endif
`ifndef R
`define R 1
`endif

package ifetch_pkg;

    typedef enum logic [1:0] {
        FS_HI   = 2'd0,
        FS_LO   = 2'd1,
        FS_FULL = 2'd2,
        FS_DROP = 2'd3
    } fetch_state_e;

    localparam int IW = 32;
    localparam int HW = 16;

endpackage

// File: rtl/ifetch_ifq.sv
// Prefetch queue: DEPTH entries of instruction word plus its byte address.
// Head outputs read as zero while the queue is empty.
module ifq_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [IW-1:0]            push_data,
    input  logic [AW-1:0]            push_tag,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [IW-1:0]            head_data,
    output logic [AW-1:0]            head_tag
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [IW-1:0] data_q [DEPTH];
    logic [AW-1:0] tag_q  [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt_q;

    // Pointer and occupancy bookkeeping; flush empties the queue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Entry storage, written at the tail.
    always_ff @(posedge clk) begin
        if (rst && !flush && push) begin
            data_q[wr_ptr] <= push_data;
            tag_q[wr_ptr]  <= push_tag;
        end
    end

    assign count     = cnt_q;
    assign head_data = (cnt_q != '0) ? data_q[rd_ptr] : '0;
    assign head_tag  = (cnt_q != '0) ? tag_q[rd_ptr]  : '0;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: assembles 32-bit words from two halfword
// reads and feeds decode through a small prefetch queue.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int            DEPTH    = 2,
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [`PHASE_H:0]   phase,
    input  logic                redirect,
    input  logic [AW-1:0]       redirect_pc,
    output logic                mem_req,
    output logic [AW-1:0]       mem_addr,
    input  logic                mem_ack,
    input  logic [HW-1:0]       mem_rdata,
    output logic [IW-1:0]       ir_out,
    output logic                ir_valid,
    output logic [AW-1:0]       pc_of_ir,
    output logic                fetch_stall
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q;
    fetch_state_e  state_d;
    logic [AW-1:0] fetch_pc_q;
    logic [AW-1:0] drop_addr_q;
    logic [HW-1:0] hi_q;
    logic [CW-1:0] count;
    logic [CW-1:0] cnt_next;
    logic          push;
    logic          pop;
    logic          unused_bits;

    assign unused_bits = ^{phase, redirect_pc[1:0]};

    assign pop         = phase[`R] & ir_valid & ~redirect;
    assign push        = (state_q == FS_LO) & mem_ack & ~redirect;
    assign cnt_next    = count + CW'(push) - CW'(pop);
    assign ir_valid    = (count != '0);
    assign fetch_stall = phase[`R] & ~ir_valid;

    ifq_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ifq (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data ({hi_q, mem_rdata}),
        .push_tag  (fetch_pc_q),
        .pop       (pop),
        .count     (count),
        .head_data (ir_out),
        .head_tag  (pc_of_ir)
    );

    // Request decode from registered state only.
    always_comb begin
        mem_req  = 1'b1;
        mem_addr = fetch_pc_q;
        unique case (state_q)
            FS_HI:   mem_addr = fetch_pc_q;
            FS_LO:   mem_addr = fetch_pc_q + AW'(2);
            FS_FULL: mem_req  = 1'b0;
            FS_DROP: mem_addr = drop_addr_q;
            default: mem_req  = 1'b0;
        endcase
    end

    // Next fetch state; redirect abandons an unacked read via DROP.
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            unique case (state_q)
                FS_HI, FS_LO: state_d = mem_ack ? FS_HI : FS_DROP;
                FS_DROP:      state_d = FS_DROP;
                default:      state_d = FS_HI;
            endcase
        end else begin
            unique case (state_q)
                FS_HI:   if (mem_ack) state_d = FS_LO;
                FS_LO: begin
                    if (mem_ack)
                        state_d = (cnt_next == CW'(DEPTH)) ? FS_FULL : FS_HI;
                end
                FS_FULL: if (cnt_next < CW'(DEPTH)) state_d = FS_HI;
                FS_DROP: if (mem_ack) state_d = FS_HI;
                default: state_d = FS_HI;
            endcase
        end
    end

    // State, fetch address, first-halfword and dropped-address registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= FS_HI;
            fetch_pc_q  <= RESET_PC;
            hi_q        <= '0;
            drop_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (redirect) begin
                fetch_pc_q <= {redirect_pc[AW-1:2], 2'b00};
                hi_q       <= '0;
                if (state_q != FS_DROP) drop_addr_q <= mem_addr;
            end else begin
                if (push) fetch_pc_q <= fetch_pc_q + AW'(4);
                if (state_q == FS_HI && mem_ack) hi_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for the fetch stage with a latency-programmable
// halfword memory model.
`ifndef PHASE_H
`define PHASE_H 3
`endif
`ifndef R
`define R 1
`endif

module tb_ifetch;

    logic              clk = 1'b0;
    logic              rst;
    logic [`PHASE_H:0] phase;
    logic              redirect;
    logic [15:0]       redirect_pc;
    logic              mem_req;
    logic [15:0]       mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_rdata;
    logic [31:0]       ir_out;
    logic              ir_valid;
    logic [15:0]       pc_of_ir;
    logic              fetch_stall;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 0;
    int wait_cnt = 0;
    logic ack_en = 1'b1;
    logic mon_en = 1'b0;
    int stall_cycles = 0;
    logic [47:0] mon_q [$];

    ifetch #(
        .DEPTH    (2),
        .AW       (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .phase       (phase),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ir_out      (ir_out),
        .ir_valid    (ir_valid),
        .pc_of_ir    (pc_of_ir),
        .fetch_stall (fetch_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] hw(input logic [15:0] a);
        if (a == 16'h0000) return 16'h1234;
        if (a == 16'h0002) return 16'h5678;
        return a ^ 16'hA5A5;
    endfunction

    function automatic logic [31:0] word(input logic [15:0] p);
        return {hw(p), hw(p + 16'd2)};
    endfunction

    assign mem_rdata = hw(mem_addr);
    assign mem_ack   = ack_en && mem_req && (wait_cnt >= lat);

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (phase[`R] && ir_valid && !redirect)
                mon_q.push_back({pc_of_ir, ir_out});
            if (fetch_stall) stall_cycles++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs,
                       input logic [47:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic found;
        rst = 1'b0;
        phase = '0;
        redirect = 1'b0;
        redirect_pc = '0;
        tick();
        tick();
        chk("rst_valid", 48'(ir_valid), 48'd0);
        chk("rst_ir", 48'(ir_out), 48'd0);
        chk("rst_pc", 48'(pc_of_ir), 48'd0);
        chk("rst_addr", 48'(mem_addr), 48'd0);

        // zero-wait fetch from reset
        rst = 1'b1;
        #1;
        chk("c0_req", 48'(mem_req), 48'd1);
        chk("c0_addr", 48'(mem_addr), 48'h0);
        tick();
        chk("c1_addr", 48'(mem_addr), 48'h2);
        chk("c1_valid", 48'(ir_valid), 48'd0);
        tick();
        chk("c2_valid", 48'(ir_valid), 48'd1);
        chk("c2_ir", 48'(ir_out), 48'h12345678);
        chk("c2_pc", 48'(pc_of_ir), 48'h0);
        chk("c2_addr", 48'(mem_addr), 48'h4);
        tick();
        chk("c3_addr", 48'(mem_addr), 48'h6);
        tick();
        chk("full_req", 48'(mem_req), 48'd0);
        tick();
        chk("full_hold", 48'(mem_req), 48'd0);
        chk("full_head", 48'(ir_out), 48'h12345678);
        phase[`R] = 1'b1;
        #1;
        chk("nostall", 48'(fetch_stall), 48'd0);
        tick();
        phase[`R] = 1'b0;
        chk("refill_req", 48'(mem_req), 48'd1);
        chk("refill_addr", 48'(mem_addr), 48'h8);
        chk("pop1_ir", 48'(ir_out), 48'(word(16'h4)));
        chk("pop1_pc", 48'(pc_of_ir), 48'h4);
        tick();
        chk("refill_lo", 48'(mem_addr), 48'hA);
        tick();
        chk("full2_req", 48'(mem_req), 48'd0);

        // pop with LO ack in the same cycle
        phase[`R] = 1'b1;
        tick();
        phase[`R] = 1'b0;
        chk("pp_head8", 48'(pc_of_ir), 48'h8);
        chk("pp_addrC", 48'(mem_addr), 48'hC);
        tick();
        chk("pp_lo", 48'(mem_addr), 48'hE);
        phase[`R] = 1'b1;
        tick();
        phase[`R] = 1'b0;
        chk("pp_valid", 48'(ir_valid), 48'd1);
        chk("pp_ir", 48'(ir_out), 48'(word(16'hC)));
        chk("pp_pc", 48'(pc_of_ir), 48'hC);
        chk("pp_addr", 48'(mem_addr), 48'h10);

        // pop together with redirect
        phase[`R] = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        chk("rd_valid", 48'(ir_valid), 48'd0);
        chk("rd_stall", 48'(fetch_stall), 48'd1);
        chk("rd_addr", 48'(mem_addr), 48'h40);
        phase[`R] = 1'b0;
        tick();
        chk("rd_lo", 48'(mem_addr), 48'h42);
        tick();
        chk("rd_ir", 48'(ir_out), 48'(word(16'h40)));
        chk("rd_pc", 48'(pc_of_ir), 48'h40);

        // redirect during an unacked LO read
        tick();
        ack_en = 1'b0;
        #1;
        chk("drop_lo", 48'(mem_addr), 48'h46);
        redirect = 1'b1;
        redirect_pc = 16'h0103;
        tick();
        redirect = 1'b0;
        chk("drop_req", 48'(mem_req), 48'd1);
        chk("drop_addr", 48'(mem_addr), 48'h46);
        chk("drop_valid", 48'(ir_valid), 48'd0);
        tick();
        chk("drop_hold", 48'(mem_addr), 48'h46);
        ack_en = 1'b1;
        tick();
        chk("drop_new", 48'(mem_addr), 48'h100);
        chk("drop_v1", 48'(ir_valid), 48'd0);
        tick();
        chk("drop_v2", 48'(ir_valid), 48'd0);
        tick();
        chk("drop_ir", 48'(ir_out), 48'(word(16'h100)));
        chk("drop_pc", 48'(pc_of_ir), 48'h100);

        // slow memory, decode consuming every cycle
        lat = 3;
        phase[`R] = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'h0200;
        tick();
        redirect = 1'b0;
        mon_q.delete();
        stall_cycles = 0;
        mon_en = 1'b1;
        chk("slow_stall", 48'(fetch_stall), 48'd1);
        for (int i = 0; i < 200 && mon_q.size() < 4; i++) tick();
        mon_en = 1'b0;
        phase[`R] = 1'b0;
        chk("slow_cnt", 48'(mon_q.size()), 48'd4);
        for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
            logic [15:0] p;
            p = 16'h0200 + 16'(4 * i);
            chk("slow_word", mon_q[i], {p, word(p)});
        end
        chk("slow_stalled", 48'(stall_cycles > 8), 48'd1);

        // reset in the middle of a pending LO read
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (mem_req && mem_addr[1] && !mem_ack) found = 1'b1;
            else tick();
        end
        chk("mid_lo", 48'(found), 48'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mr_valid", 48'(ir_valid), 48'd0);
        chk("mr_req", 48'(mem_req), 48'd1);
        chk("mr_addr", 48'(mem_addr), 48'h0);

        // address wrap at the top of memory
        lat = 0;
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        chk("wr_hi", 48'(mem_addr), 48'hFFFC);
        tick();
        chk("wr_lo", 48'(mem_addr), 48'hFFFE);
        tick();
        chk("wr_addr", 48'(mem_addr), 48'h0000);
        chk("wr_pc", 48'(pc_of_ir), 48'hFFFC);
        chk("wr_ir", 48'(ir_out), 48'(word(16'hFFFC)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
